// File: rtl/exec_seq_ctrl_pkg.sv
// rtl/exec_seq_ctrl_pkg.sv - shared widths, opcodes and FSM encoding for the execution sequencer
// Contents: OPR_W/DLY_W widths, DLY_WAIT sentinel, decoder opcode constants,
//           2-bit sequencer state type, opr_known() helper.
package exec_seq_ctrl_pkg;

    localparam int OPR_W = 5;
    localparam int DLY_W = 8;

    // Delay value meaning "wait for alu_done" instead of a fixed count.
    localparam logic [DLY_W-1:0] DLY_WAIT = 8'd255;

    localparam logic [OPR_W-1:0] OPR_NOP = 5'd0;
    localparam logic [OPR_W-1:0] OPR_ADD = 5'd1;
    localparam logic [OPR_W-1:0] OPR_SUB = 5'd2;
    localparam logic [OPR_W-1:0] OPR_MOV = 5'd3;
    localparam logic [OPR_W-1:0] OPR_MUL = 5'd4;
    localparam logic [OPR_W-1:0] JMP_OPR = 5'd16;
    localparam logic [OPR_W-1:0] JRE_OPR = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } seq_state_t;

    // Opcodes the decoder actually produces; anything else without a delay is a NOP.
    function automatic logic opr_known(input logic [OPR_W-1:0] opr);
        return opr inside {OPR_ADD, OPR_SUB, OPR_MOV, OPR_MUL, JMP_OPR, JRE_OPR};
    endfunction

endpackage

// File: rtl/exec_seq_ctrl_if.sv
// rtl/exec_seq_ctrl_if.sv - decoder/ALU/PC handshake bundle for the execution sequencer
// master: decoder/datapath side (drives dec_*, alu_done, jre_taken, flush, err_clr)
// slave : sequencer side (drives dec_rdy, ex_start, alu_start, busy, wb_en, pc_inc, pc_load, err)
interface exec_seq_ctrl_if
    import exec_seq_ctrl_pkg::*;
();
    logic             dec_vld;
    logic             dec_rdy;
    logic [OPR_W-1:0] dec_opr;
    logic             dec_alu_sel;
    logic             dec_dly_sel;
    logic [DLY_W-1:0] dec_dly;
    logic             alu_done;
    logic             jre_taken;
    logic             flush;
    logic             err_clr;
    logic             ex_start;
    logic             alu_start;
    logic             busy;
    logic             wb_en;
    logic             pc_inc;
    logic             pc_load;
    logic             err;

    modport master (
        output dec_vld, dec_opr, dec_alu_sel, dec_dly_sel, dec_dly,
               alu_done, jre_taken, flush, err_clr,
        input  dec_rdy, ex_start, alu_start, busy, wb_en, pc_inc, pc_load, err
    );

    modport slave (
        input  dec_vld, dec_opr, dec_alu_sel, dec_dly_sel, dec_dly,
               alu_done, jre_taken, flush, err_clr,
        output dec_rdy, ex_start, alu_start, busy, wb_en, pc_inc, pc_load, err
    );
endinterface

// File: rtl/exec_seq_ctrl_delay_cnt.sv
// rtl/exec_seq_ctrl_delay_cnt.sv - loadable delay down-counter with sentinel wait-for-done and timeout
// Ports: clk, rst (sync active-high), load (ISSUE cycle), run (WAIT cycles), dly (count to load),
//        alu_done (completion pulse), expire (leave WAIT next edge), timeout (sentinel wait gave up).
module seq_delay_cnt
    import exec_seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [DLY_W-1:0] dly,
    input  logic             alu_done,
    output logic             expire,
    output logic             timeout
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [DLY_W-1:0] cnt;
    logic [TW-1:0]    tcnt;
    logic             sentinel;
    logic             done_seen;
    logic             done_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            tcnt      <= '0;
            sentinel  <= 1'b0;
            done_seen <= 1'b0;
        end else if (load) begin
            cnt       <= dly;
            tcnt      <= '0;
            sentinel  <= (dly == DLY_WAIT);
            // A completion that races the ISSUE cycle must not be lost.
            done_seen <= alu_done;
        end else if (run) begin
            if (sentinel) begin
                tcnt      <= tcnt + 1'b1;
                done_seen <= done_seen | alu_done;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        done_any = done_seen | alu_done;
        expire   = run & (sentinel ? done_any : (cnt == 8'd1));
        // Completion wins over a timeout landing in the same cycle.
        timeout  = run & sentinel & ~done_any & (tcnt == TW'(TIMEOUT - 1));
    end
endmodule

// File: rtl/exec_seq_ctrl.sv
// rtl/exec_seq_ctrl.sv - execution sequencer: issue, per-instruction latency, write-back/PC strobes
// Ports: clk, rst (sync active-high), bus (exec_seq_ctrl_if.slave: decoder handshake,
//        ALU completion, jump condition, flush/err_clr in; start, write-back, PC and err out).
module exec_seq_ctrl
    import exec_seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 4095
) (
    input  logic           clk,
    input  logic           rst,
    exec_seq_ctrl_if.slave bus
);
    seq_state_t       state;
    logic [OPR_W-1:0] opr_q;
    logic [DLY_W-1:0] dly_q;
    logic             nop_q;

    logic dec_rdy_q, busy_q, ex_start_q, alu_start_q;
    logic wb_en_q, pc_inc_q, pc_load_q, err_q;

    logic expire, timeout;
    logic is_jmp, is_jre, wb_load_c, wb_inc_c, wb_wen_c;

    seq_delay_cnt #(.TIMEOUT(TIMEOUT)) u_delay_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_ISSUE),
        .run      (state == ST_WAIT),
        .dly      (dly_q),
        .alu_done (bus.alu_done),
        .expire   (expire),
        .timeout  (timeout)
    );

    // Strobe values for the WB cycle, registered on the edge that enters WB.
    always_comb begin
        is_jmp    = (opr_q == JMP_OPR);
        is_jre    = (opr_q == JRE_OPR);
        wb_load_c = is_jmp | (is_jre & bus.jre_taken);
        wb_inc_c  = is_jre ? ~bus.jre_taken : ~is_jmp;
        wb_wen_c  = ~is_jmp & ~is_jre & ~nop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            opr_q       <= '0;
            dly_q       <= '0;
            nop_q       <= 1'b0;
            dec_rdy_q   <= 1'b1;
            busy_q      <= 1'b0;
            ex_start_q  <= 1'b0;
            alu_start_q <= 1'b0;
            wb_en_q     <= 1'b0;
            pc_inc_q    <= 1'b0;
            pc_load_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ex_start_q  <= 1'b0;
            alu_start_q <= 1'b0;
            wb_en_q     <= 1'b0;
            pc_inc_q    <= 1'b0;
            pc_load_q   <= 1'b0;
            if (bus.err_clr) err_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.dec_vld) begin
                        opr_q       <= bus.dec_opr;
                        dly_q       <= bus.dec_dly_sel ? bus.dec_dly : '0;
                        nop_q       <= (bus.dec_opr == OPR_NOP) |
                                       (~opr_known(bus.dec_opr) & ~bus.dec_dly_sel);
                        ex_start_q  <= 1'b1;
                        alu_start_q <= bus.dec_alu_sel;
                        dec_rdy_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.flush) begin
                        state     <= ST_IDLE;
                        dec_rdy_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else if (dly_q == '0) begin
                        wb_en_q   <= wb_wen_c;
                        pc_inc_q  <= wb_inc_c;
                        pc_load_q <= wb_load_c;
                        state     <= ST_WB;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.flush) begin
                        state     <= ST_IDLE;
                        dec_rdy_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else if (timeout | expire) begin
                        // A timed-out result is garbage: advance the PC but never write it.
                        if (timeout) err_q <= 1'b1;
                        wb_en_q   <= wb_wen_c & ~timeout;
                        pc_inc_q  <= wb_inc_c;
                        pc_load_q <= wb_load_c;
                        state     <= ST_WB;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    dec_rdy_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dec_rdy   = dec_rdy_q;
    assign bus.busy      = busy_q;
    assign bus.ex_start  = ex_start_q;
    assign bus.alu_start = alu_start_q;
    assign bus.wb_en     = wb_en_q;
    assign bus.pc_inc    = pc_inc_q;
    assign bus.pc_load   = pc_load_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_exec_seq_ctrl.sv
// tb/tb_exec_seq_ctrl.sv - self-checking bench for exec_seq_ctrl
module tb_exec_seq_ctrl;
    import exec_seq_ctrl_pkg::*;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic model_err = 1'b0;

    exec_seq_ctrl_if bus ();

    exec_seq_ctrl #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_inputs();
        bus.dec_vld     = 1'b0;
        bus.dec_opr     = '0;
        bus.dec_alu_sel = 1'b0;
        bus.dec_dly_sel = 1'b0;
        bus.dec_dly     = '0;
        bus.alu_done    = 1'b0;
        bus.jre_taken   = 1'b0;
        bus.flush       = 1'b0;
        bus.err_clr     = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".dec_rdy"}, bus.dec_rdy, 1);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".strobes"}, {bus.ex_start, bus.alu_start, bus.wb_en, bus.pc_inc, bus.pc_load}, 0);
    endtask

    // Issue one instruction and compare its whole timeline with the rules of the sequencer.
    // done_at/flush_at: offset from the accept cycle at which that input is pulsed (-1 = never).
    task automatic run_instr(input string tag, input logic [4:0] opr, input logic asel,
                             input logic dsel, input logic [7:0] dly, input int done_at,
                             input logic jre, input int flush_at, input logic noise);
        int   t, wb_exp, ex_cyc, nex, wb_cyc, nstrobe, idle_cyc, k;
        logic alu_st, wbv, incv, ldv, errv;
        logic [7:0] d;
        logic sent, nop, abort, e_wen, e_inc, e_ld;

        k = 0;
        while (!bus.dec_rdy && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".rdy_wait"}, bus.dec_rdy, 1);

        bus.dec_opr     = opr;
        bus.dec_alu_sel = asel;
        bus.dec_dly_sel = dsel;
        bus.dec_dly     = dly;
        bus.jre_taken   = jre;
        bus.dec_vld     = 1'b1;
        t = cyc;

        d     = dsel ? dly : 8'd0;
        sent  = (d == 8'd255);
        nop   = (opr == 5'd0) || (!dsel && !(opr inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd16, 5'd17}));
        abort = sent && done_at < 0 && flush_at < 0;
        if (flush_at >= 0)  wb_exp = -1;
        else if (!sent)     wb_exp = t + 2 + d;
        else if (done_at < 0) wb_exp = -1;
        else                wb_exp = t + ((done_at < 2) ? 2 : done_at) + 1;
        if (opr == 5'd16) begin
            e_ld = 1; e_inc = 0; e_wen = 0;
        end else if (opr == 5'd17) begin
            e_ld = jre; e_inc = !jre; e_wen = 0;
        end else begin
            e_ld = 0; e_inc = 1; e_wen = !nop && !abort;
        end

        ex_cyc = -1; nex = 0; wb_cyc = -1; nstrobe = 0; idle_cyc = -1;
        alu_st = 0; wbv = 0; incv = 0; ldv = 0; errv = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.dec_vld = 1'b0;
                bus.dec_opr = 5'($urandom);
                bus.dec_dly = 8'($urandom);
            end
            if (bus.ex_start) begin
                if (ex_cyc < 0) begin
                    ex_cyc = cyc;
                    alu_st = bus.alu_start;
                end
                nex++;
            end
            if (bus.wb_en || bus.pc_inc || bus.pc_load) begin
                nstrobe++;
                wb_cyc = cyc;
                wbv = bus.wb_en; incv = bus.pc_inc; ldv = bus.pc_load; errv = bus.err;
            end
            if (bus.dec_rdy) begin
                idle_cyc = cyc;
                break;
            end
            bus.alu_done = (i == done_at) || (noise && !sent && ($urandom_range(0, 1) == 1));
            bus.flush    = (i == flush_at);
        end
        bus.alu_done = 1'b0;
        bus.flush    = 1'b0;
        if (abort) model_err = 1'b1;

        chk({tag, ".finished"}, (idle_cyc >= 0), 1);
        chk({tag, ".ex_cyc"}, ex_cyc - t, 1);
        chk({tag, ".ex_cnt"}, nex, 1);
        chk({tag, ".alu_start"}, alu_st, asel);
        if (flush_at >= 0) begin
            chk({tag, ".flush_strobes"}, nstrobe, 0);
            chk({tag, ".flush_idle"}, idle_cyc - t, flush_at + 1);
        end else begin
            chk({tag, ".wb_cnt"}, nstrobe, 1);
            if (wb_exp >= 0) chk({tag, ".wb_cyc"}, wb_cyc - t, wb_exp - t);
            chk({tag, ".rdy_back"}, idle_cyc - wb_cyc, 1);
            chk({tag, ".wb_en"}, wbv, e_wen);
            chk({tag, ".pc_inc"}, incv, e_inc);
            chk({tag, ".pc_load"}, ldv, e_ld);
            chk({tag, ".err"}, errv, model_err);
        end
    endtask

    initial begin
        logic [4:0] ops [8];
        logic [4:0] ro;
        logic       rs, rsel;
        logic [7:0] rd;
        int         rdone, rflush;

        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd16, 5'd17, 5'd9};
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset.err", bus.err, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1. fixed delay ALU op
        run_instr("add_d4", OPR_ADD, 1, 1, 8'd4, -1, 0, -1, 0);
        run_instr("add_d0", OPR_ADD, 1, 1, 8'd0, -1, 0, -1, 0);
        run_instr("sub_d1_noise", OPR_SUB, 0, 1, 8'd1, -1, 0, -1, 1);
        // 2. sentinel wait, plus completion racing ISSUE, plus stray completion in IDLE
        run_instr("mul_wait", OPR_MUL, 1, 1, 8'd255, 12, 0, -1, 0);
        bus.alu_done = 1'b1;
        @(negedge clk);
        bus.alu_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_idle_outputs("stray_done");
            @(negedge clk);
        end
        run_instr("mul_early", OPR_MUL, 1, 1, 8'd255, 1, 0, -1, 0);
        // 3. sentinel timeout; err sticky until err_clr
        run_instr("mov_tmo", OPR_MOV, 1, 1, 8'd255, -1, 0, -1, 0);
        chk("err_sticky", bus.err, 1);
        run_instr("add_after_tmo", OPR_ADD, 1, 1, 8'd2, -1, 0, -1, 0);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        model_err = 1'b0;
        chk("err_clr", bus.err, 0);
        // 4. jumps
        run_instr("jre_taken", JRE_OPR, 0, 1, 8'd7, -1, 1, -1, 0);
        run_instr("jre_not", JRE_OPR, 0, 1, 8'd7, -1, 0, -1, 0);
        run_instr("jmp_d3", JMP_OPR, 0, 1, 8'd3, -1, 0, -1, 0);
        // 5. flush in WAIT then a normal instruction
        run_instr("mov_flush", OPR_MOV, 0, 1, 8'd1, -1, 0, 2, 0);
        run_instr("mov_after", OPR_MOV, 0, 1, 8'd1, -1, 0, -1, 0);
        // 6. reset mid-WAIT, then NOP
        bus.dec_opr = OPR_MOV; bus.dec_dly_sel = 1; bus.dec_dly = 8'd20; bus.dec_vld = 1;
        @(negedge clk);
        bus.dec_vld = 0;
        repeat (5) @(negedge clk);
        chk("mid_wait.busy", bus.busy, 1);
        rst = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        chk_idle_outputs("rst_mid");
        chk("rst_mid.err", bus.err, 0);
        rst = 1'b0;
        bus.flush = 1'b0;
        model_err = 1'b0;
        run_instr("nop", OPR_NOP, 0, 0, 8'd9, -1, 0, -1, 0);
        run_instr("unknown_nop", 5'd12, 1, 0, 8'd5, -1, 0, -1, 0);

        // randomized
        for (int n = 0; n < 40; n++) begin
            ro    = ops[$urandom_range(0, 7)];
            rsel  = ($urandom_range(0, 3) != 0);
            rs    = ($urandom_range(0, 4) == 0);
            rd    = rs ? 8'd255 : 8'($urandom_range(0, 12));
            rdone = rs ? (($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 14))) : -1;
            rflush = -1;
            if (!(rsel && rs) && ($urandom_range(0, 5) == 0))
                rflush = int'($urandom_range(1, (rsel ? rd : 8'd0) + 1));
            run_instr("rand", ro, 1'($urandom), rsel, rd, rdone, 1'($urandom), rflush, 1'($urandom));
            if (model_err && $urandom_range(0, 1) == 1) begin
                bus.err_clr = 1'b1;
                @(negedge clk);
                bus.err_clr = 1'b0;
                model_err = 1'b0;
                chk("rand.err_clr", bus.err, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
